// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART transmit arbiter
package uart_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int STATE_W    = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } arb_state_e;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rtl/uart_tx_arbiter_rr_pick.sv - combinational round-robin picker: first request above ptr, wrapping
module rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         win,
  output logic [$clog2(N)-1:0] win_idx,
  output logic                 valid
);

  localparam int PTR_W = $clog2(N);

  int               cand;
  logic [PTR_W-1:0] cand_idx;

  // Scan ptr+1, ptr+2, ... wrapping, and keep the first requester found.
  always_comb begin
    win      = '0;
    win_idx  = '0;
    valid    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int i = 1; i <= N; i++) begin
      cand     = (int'(ptr) + i) % N;
      cand_idx = PTR_W'(cand);
      if (!valid && req[cand_idx]) begin
        valid         = 1'b1;
        win[cand_idx] = 1'b1;
        win_idx       = cand_idx;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin sharing of one UART transmitter; packet lock under UART_ARB_LOCK_EN
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int BUSY_TO = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  input  logic [N_REQ-1:0]        req_last,
  output logic [N_REQ-1:0]        ack,
  output logic [N_REQ-1:0]        grant,
  output logic [DATA_W-1:0]       tx_data,
  output logic                    tx_start,
  input  logic                    tx_busy,
  output logic                    arb_busy,
  output logic                    err_to
);

  localparam int PTR_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(BUSY_TO) + 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(BUSY_TO - 1);

  arb_state_e        state_q, state_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [N_REQ-1:0]  grant_q, grant_d;
  logic [N_REQ-1:0]  ack_q, ack_d;
  logic              tx_start_q, tx_start_d;
  logic              err_to_q, err_to_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;

  logic [N_REQ-1:0]  pick_req;
  logic [N_REQ-1:0]  pick_win;
  logic [PTR_W-1:0]  pick_idx;
  logic              pick_valid;
  logic              take;
  logic              to_fire;

  logic [DATA_W-1:0] slot [N_REQ];

  // Unpack the flat request data bus into one byte per requester.
  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      slot[i] = req_data[i*DATA_W +: DATA_W];
    end
  end

`ifdef UART_ARB_LOCK_EN
  logic             lock_vld_q, lock_vld_d;
  logic [PTR_W-1:0] lock_id_q, lock_id_d;

  // While a packet owner is locked and still requesting, it is the only candidate.
  always_comb begin
    pick_req = req;
    if (lock_vld_q && req[lock_id_q]) begin
      pick_req            = '0;
      pick_req[lock_id_q] = 1'b1;
    end
  end

  // Lock follows the last flag of each granted byte; dropped owner or timeout frees the line.
  always_comb begin
    lock_vld_d = lock_vld_q;
    lock_id_d  = lock_id_q;
    if (state_q == IDLE && lock_vld_q && !req[lock_id_q]) begin
      lock_vld_d = 1'b0;
    end
    if (take) begin
      lock_vld_d = !req_last[pick_idx];
      lock_id_d  = pick_idx;
    end
    if (to_fire) begin
      lock_vld_d = 1'b0;
    end
  end

  // Lock register.
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_vld_q <= 1'b0;
      lock_id_q  <= '0;
    end else begin
      lock_vld_q <= lock_vld_d;
      lock_id_q  <= lock_id_d;
    end
  end
`else
  logic unused_req_last;
  assign unused_req_last = ^req_last;

  // Pure per-byte round robin: every requester is a candidate.
  always_comb begin
    pick_req = req;
  end
`endif

  rr_pick #(
    .N (N_REQ)
  ) u_rr_pick (
    .req     (pick_req),
    .ptr     (ptr_q),
    .win     (pick_win),
    .win_idx (pick_idx),
    .valid   (pick_valid)
  );

  // Next-state and next-output logic for the transfer sequencer.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    grant_d    = grant_q;
    ack_d      = '0;
    tx_start_d = 1'b0;
    err_to_d   = 1'b0;
    tx_data_d  = tx_data_q;
    take       = 1'b0;
    to_fire    = 1'b0;
    case (state_q)
      IDLE: begin
        // A busy line here means someone else is driving the transmitter; hold off.
        if (pick_valid && !tx_busy) begin
          take      = 1'b1;
          grant_d   = pick_win;
          ack_d     = pick_win;
          tx_data_d = slot[pick_idx];
          ptr_d     = pick_idx;
          state_d   = LAUNCH;
        end
      end
      LAUNCH: begin
        tx_start_d = 1'b1;
        cnt_d      = '0;
        state_d    = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = WAIT_DONE;
        end else if (cnt_q == TO_LAST) begin
          // Byte is abandoned; it was already acked so the producer has moved on.
          to_fire  = 1'b1;
          err_to_d = 1'b1;
          grant_d  = '0;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          grant_d = '0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, pointer, counter and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= PTR_W'(N_REQ - 1);
      cnt_q      <= '0;
      grant_q    <= '0;
      ack_q      <= '0;
      tx_start_q <= 1'b0;
      err_to_q   <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      grant_q    <= grant_d;
      ack_q      <= ack_d;
      tx_start_q <= tx_start_d;
      err_to_q   <= err_to_d;
      tx_data_q  <= tx_data_d;
    end
  end

  assign ack      = ack_q;
  assign grant    = grant_q;
  assign tx_data  = tx_data_q;
  assign tx_start = tx_start_q;
  assign err_to   = err_to_q;
  assign arb_busy = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

  localparam int N_REQ   = 4;
  localparam int DATA_W  = 8;
  localparam int BUSY_TO = 16;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [N_REQ-1:0]        req;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [N_REQ-1:0]        req_last;
  logic [N_REQ-1:0]        ack;
  logic [N_REQ-1:0]        grant;
  logic [DATA_W-1:0]       tx_data;
  logic                    tx_start;
  logic                    tx_busy;
  logic                    arb_busy;
  logic                    err_to;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .N_REQ   (N_REQ),
    .DATA_W  (DATA_W),
    .BUSY_TO (BUSY_TO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .req_data (req_data),
    .req_last (req_last),
    .ack      (ack),
    .grant    (grant),
    .tx_data  (tx_data),
    .tx_start (tx_start),
    .tx_busy  (tx_busy),
    .arb_busy (arb_busy),
    .err_to   (err_to)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full transfer for requester idx: ack, launch, a short frame, back to IDLE.
  task automatic xfer(input int idx);
    int t;
    logic [7:0] d;
    d = req_data[idx*8 +: 8];
    t = 0;
    while (ack == '0 && t < 40) begin
      @(negedge clk);
      t++;
    end
    chk("xfer_ack", 32'(ack), 32'(1 << idx));
    chk("xfer_grant", 32'(grant), 32'(1 << idx));
    @(negedge clk);
    chk("xfer_start", 32'(tx_start), 32'd1);
    chk("xfer_data", 32'(tx_data), 32'(d));
    chk("xfer_ack_once", 32'(ack), 32'd0);
    tx_busy = 1'b1;
    repeat (4) @(negedge clk);
    tx_busy = 1'b0;
    @(negedge clk);
    t = 0;
    while (arb_busy && t < 10) begin
      @(negedge clk);
      t++;
    end
    chk("xfer_idle", 32'(arb_busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "bench timeout");
  end

  initial begin
    int t;
    int bad;
    int n0;
    int exp6 [5];
`ifdef UART_ARB_LOCK_EN
    exp6 = '{0, 0, 0, 1, 1};
`else
    exp6 = '{0, 1, 0, 1, 0};
`endif

    // 1: reset held two cycles with every requester asking
    rst      = 1'b1;
    req      = 4'hF;
    req_data = 32'h4433_2211;
    req_last = 4'hF;
    tx_busy  = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("rst_ack", 32'(ack), 32'd0);
      chk("rst_grant", 32'(grant), 32'd0);
      chk("rst_start", 32'(tx_start), 32'd0);
      chk("rst_err", 32'(err_to), 32'd0);
      chk("rst_busy", 32'(arb_busy), 32'd0);
    end
    rst = 1'b0;
    req = 4'h0;
    @(negedge clk);

    // 2: single requester 2, byte A5, frame 20 cycles
    req_data[23:16] = 8'hA5;
    req = 4'b0100;
    @(negedge clk);
    chk("t2_ack", 32'(ack), 32'h4);
    chk("t2_grant", 32'(grant), 32'h4);
    chk("t2_nostart", 32'(tx_start), 32'd0);
    chk("t2_arb_busy", 32'(arb_busy), 32'd1);
    req = 4'b0000;
    @(negedge clk);
    chk("t2_start", 32'(tx_start), 32'd1);
    chk("t2_ack_done", 32'(ack), 32'd0);
    chk("t2_data", 32'(tx_data), 32'hA5);
    chk("t2_grant_hold", 32'(grant), 32'h4);
    @(negedge clk);
    chk("t2_start_pulse", 32'(tx_start), 32'd0);
    @(negedge clk);
    tx_busy = 1'b1;
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (grant !== 4'b0100) bad++;
    end
    chk("t2_grant_frame", 32'(bad), 32'd0);
    tx_busy = 1'b0;
    @(negedge clk);
    chk("t2_grant_clr", 32'(grant), 32'd0);
    chk("t2_idle", 32'(arb_busy), 32'd0);

    // 3: all four requesting, eight transfers rotate 0,1,2,3,0,1,2,3
    rst = 1'b1;
    @(negedge clk);
    rst      = 1'b0;
    req_data = 32'h4433_2211;
    req_last = 4'hF;
    req      = 4'hF;
    for (int k = 0; k < 8; k++) begin
      xfer(k % 4);
    end
    req = 4'h0;
    @(negedge clk);

    // 4: transmitter never answers -> timeout BUSY_TO cycles after tx_start
    req_data[15:8] = 8'h3C;
    req = 4'b0010;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (ack == '0 && t < 20);
    chk("t4_ack", 32'(ack), 32'h2);
    req = 4'b0000;
    @(negedge clk);
    chk("t4_start", 32'(tx_start), 32'd1);
    chk("t4_data", 32'(tx_data), 32'h3C);
    bad = 0;
    for (int i = 1; i < BUSY_TO; i++) begin
      @(negedge clk);
      if (err_to !== 1'b0) bad++;
    end
    chk("t4_no_early_err", 32'(bad), 32'd0);
    @(negedge clk);
    chk("t4_err", 32'(err_to), 32'd1);
    chk("t4_idle", 32'(arb_busy), 32'd0);
    chk("t4_grant_clr", 32'(grant), 32'd0);
    @(negedge clk);
    chk("t4_err_pulse", 32'(err_to), 32'd0);
    req_data[31:24] = 8'h5A;
    req = 4'b1000;
    xfer(3);
    req = 4'b0000;
    @(negedge clk);

    // 5: reset during WAIT_DONE, then external busy blocks, then requester 1 served
    req_data[7:0] = 8'h77;
    req = 4'b0001;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (ack == '0 && t < 20);
    chk("t5_ack", 32'(ack), 32'h1);
    req = 4'b0000;
    @(negedge clk);
    tx_busy = 1'b1;
    repeat (3) @(negedge clk);
    chk("t5_in_frame", 32'(arb_busy), 32'd1);
    chk("t5_grant_frame", 32'(grant), 32'h1);
    rst = 1'b1;
    @(negedge clk);
    chk("t5_rst_grant", 32'(grant), 32'd0);
    chk("t5_rst_idle", 32'(arb_busy), 32'd0);
    chk("t5_rst_start", 32'(tx_start), 32'd0);
    rst = 1'b0;
    req_data[15:8] = 8'h99;
    req = 4'b0010;
    @(negedge clk);
    chk("t5_ext_busy_noack", 32'(ack), 32'd0);
    chk("t5_ext_busy_idle", 32'(arb_busy), 32'd0);
    tx_busy = 1'b0;
    xfer(1);
    req = 4'b0000;
    @(negedge clk);

    // 6: three-byte packet from requester 0 competing with requester 1
    rst = 1'b1;
    @(negedge clk);
    rst            = 1'b0;
    n0             = 0;
    req_data[7:0]  = 8'hB0;
    req_data[15:8] = 8'hC1;
    req_last       = 4'b0010;
    req            = 4'b0011;
    for (int k = 0; k < 5; k++) begin
      xfer(exp6[k]);
      if (exp6[k] == 0) begin
        n0++;
        req_data[7:0] = 8'(8'hB0 + n0);
        req_last[0]   = (n0 == 2);
        if (n0 == 3) req[0] = 1'b0;
      end
    end
    req = 4'b0000;
    @(negedge clk);
    chk("t6_idle", 32'(arb_busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
